// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation controller.
//   RSA_WIDTH          : default operand width (one 1024-bit memory word)
//   RSA_EXP_W          : default exponent register width
//   ONE                : Montgomery "1" operand used to leave the Montgomery domain
//   rsa_modexp_state_t : controller FSM states
package rsa_pkg;

   localparam int unsigned RSA_WIDTH = 1024;
   localparam int unsigned RSA_EXP_W = 32;

   localparam logic [RSA_WIDTH-1:0] ONE = {{(RSA_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      StIdle     = 4'd0,
      StXtIssue  = 4'd1,
      StXtWait   = 4'd2,
      StSqIssue  = 4'd3,
      StSqWait   = 4'd4,
      StMulIssue = 4'd5,
      StMulWait  = 4'd6,
      StFinIssue = 4'd7,
      StFinWait  = 4'd8,
      StDone     = 4'd9
   } rsa_modexp_state_t;

endpackage

// File: rtl/rsa_modexp_ctrl_if.sv
// Request/response channel between the exponentiation controller and the
// Montgomery multiplier.
//   mm_start  : one-cycle request pulse (controller -> multiplier)
//   mm_a/mm_b : operands, stable from mm_start until mm_done
//   mm_done   : one-cycle completion pulse (multiplier -> controller)
//   mm_result : a*b*R^-1 mod N, valid with mm_done
// Modports: master = controller side, slave = multiplier side.
interface rsa_modexp_ctrl_if #(
   parameter int unsigned WIDTH = 1024
) ();

   logic             mm_start;
   logic [WIDTH-1:0] mm_a;
   logic [WIDTH-1:0] mm_b;
   logic             mm_done;
   logic [WIDTH-1:0] mm_result;

   modport master (
      output mm_start,
      output mm_a,
      output mm_b,
      input  mm_done,
      input  mm_result
   );

   modport slave (
      input  mm_start,
      input  mm_a,
      input  mm_b,
      output mm_done,
      output mm_result
   );

endinterface

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right Montgomery square-and-multiply sequencer. Computes M^T mod N
// by issuing MontMul calls to an external multiplier.
//   clk, resetn   : clock, asynchronous active-low reset
//   start         : launch on rising edge (IDLE only)
//   m_in, r_n_in, r2_n_in, exp_in, exp_len : operands, sampled at launch
//   busy          : operation in progress
//   done          : result available (level, until start drops)
//   result        : M^T mod N, valid while done
//   mm            : multiplier channel (master side)
module rsa_modexp_ctrl
   import rsa_pkg::*;
#(
   parameter int unsigned WIDTH = RSA_WIDTH,
   parameter int unsigned EXP_W = RSA_EXP_W,
   parameter int unsigned LEN_W = 6
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [WIDTH-1:0]     m_in,
   input  logic [WIDTH-1:0]     r_n_in,
   input  logic [WIDTH-1:0]     r2_n_in,
   input  logic [EXP_W-1:0]     exp_in,
   input  logic [LEN_W-1:0]     exp_len,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result,
   rsa_modexp_ctrl_if.master    mm
);

   localparam int unsigned IdxW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

   rsa_modexp_state_t state_q, state_d;
   logic              start_q;
   logic [WIDTH-1:0]  x_q, x_d;     // M during XT, then x~ = M in Montgomery form
   logic [WIDTH-1:0]  a_q, a_d;     // R^2 mod N during XT, then the accumulator
   logic [WIDTH-1:0]  rn_q, rn_d;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic              zero_len_q, zero_len_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              mm_start_q, mm_start_d;
   logic [WIDTH-1:0]  mm_a_q, mm_a_d;
   logic [WIDTH-1:0]  mm_b_q, mm_b_d;

   logic              launch;
   logic [LEN_W-1:0]  len_clamped;
   logic              exp_bit;
   rsa_modexp_state_t step_state;
   logic [LEN_W-1:0]  step_idx;

   assign launch      = (state_q == StIdle) && start && !start_q;
   assign len_clamped = (exp_len > LEN_W'(EXP_W)) ? LEN_W'(EXP_W) : exp_len;
   assign exp_bit     = exp_q[idx_q[IdxW-1:0]];

   // Bit-step shared by the SQ (bit clear) and MUL exits.
   assign step_state  = (idx_q == '0) ? StFinIssue : StSqIssue;
   assign step_idx    = (idx_q == '0) ? idx_q : idx_q - LEN_W'(1);

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      a_d        = a_q;
      rn_d       = rn_q;
      exp_d      = exp_q;
      idx_d      = idx_q;
      zero_len_d = zero_len_q;
      result_d   = result_q;
      mm_start_d = 1'b0;
      mm_a_d     = mm_a_q;
      mm_b_d     = mm_b_q;

      unique case (state_q)
         StIdle: begin
            if (launch) begin
               x_d        = m_in;
               a_d        = r2_n_in;
               rn_d       = r_n_in;
               exp_d      = exp_in;
               idx_d      = len_clamped - LEN_W'(1);  // wraps for len=0; unused then
               zero_len_d = (len_clamped == '0);
               state_d    = StXtIssue;
            end
         end
         StXtIssue: begin
            mm_start_d = 1'b1;
            mm_a_d     = x_q;
            mm_b_d     = a_q;
            state_d    = StXtWait;
         end
         StXtWait: begin
            if (mm.mm_done) begin
               x_d     = mm.mm_result;
               a_d     = rn_q;  // 1 in Montgomery form
               state_d = zero_len_q ? StFinIssue : StSqIssue;
            end
         end
         StSqIssue: begin
            mm_start_d = 1'b1;
            mm_a_d     = a_q;
            mm_b_d     = a_q;
            state_d    = StSqWait;
         end
         StSqWait: begin
            if (mm.mm_done) begin
               a_d = mm.mm_result;
               if (exp_bit) begin
                  state_d = StMulIssue;
               end else begin
                  state_d = step_state;
                  idx_d   = step_idx;
               end
            end
         end
         StMulIssue: begin
            mm_start_d = 1'b1;
            mm_a_d     = a_q;
            mm_b_d     = x_q;
            state_d    = StMulWait;
         end
         StMulWait: begin
            if (mm.mm_done) begin
               a_d     = mm.mm_result;
               state_d = step_state;
               idx_d   = step_idx;
            end
         end
         StFinIssue: begin
            mm_start_d = 1'b1;
            mm_a_d     = a_q;
            mm_b_d     = WIDTH'(ONE);
            state_d    = StFinWait;
         end
         StFinWait: begin
            if (mm.mm_done) begin
               a_d      = mm.mm_result;
               result_d = mm.mm_result;
               state_d  = StDone;
            end
         end
         StDone: begin
            if (!start) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         start_q    <= 1'b0;
         x_q        <= '0;
         a_q        <= '0;
         rn_q       <= '0;
         exp_q      <= '0;
         idx_q      <= '0;
         zero_len_q <= 1'b0;
         result_q   <= '0;
         mm_start_q <= 1'b0;
         mm_a_q     <= '0;
         mm_b_q     <= '0;
      end else begin
         state_q    <= state_d;
         start_q    <= start;
         x_q        <= x_d;
         a_q        <= a_d;
         rn_q       <= rn_d;
         exp_q      <= exp_d;
         idx_q      <= idx_d;
         zero_len_q <= zero_len_d;
         result_q   <= result_d;
         mm_start_q <= mm_start_d;
         mm_a_q     <= mm_a_d;
         mm_b_q     <= mm_b_d;
      end
   end

   assign busy        = (state_q != StIdle) && (state_q != StDone);
   assign done        = (state_q == StDone);
   assign result      = result_q;
   assign mm.mm_start = mm_start_q;
   assign mm.mm_a     = mm_a_q;
   assign mm.mm_b     = mm_b_q;

endmodule

// File: doc/rsa_modexp_ctrl.md
Name: rsa_modexp_ctrl

Overview:
Left-to-right Montgomery square-and-multiply controller sitting between the CSR/DMA operand store and the Montgomery multiplier in the RSA wrapper. It takes the loaded operands M, R mod N and R² mod N, plus exponent T and exponent length T_LEN. It sequences multiplier calls to produce M^T mod N, then raises a level done flag that software polls through STATUS[0].

Parameters:
WIDTH, 1024, operand width in bits (matches 1024-bit memory word)
EXP_W, 32, exponent register width (CSR T)
LEN_W, 6, width of exponent-length field (must hold values 0..EXP_W)

Ports:
clk  in  1  system clock
resetn  in  1  reset; asynchronous, active-low
start  in  1  COMMAND[0] level; operation launches on its rising edge
m_in  in  WIDTH  message M, sampled at launch
r_n_in  in  WIDTH  R mod N, sampled at launch
r2_n_in  in  WIDTH  R² mod N, sampled at launch
exp_in  in  EXP_W  exponent T, sampled at launch
exp_len  in  LEN_W  number of significant exponent bits, sampled at launch
busy  out  1  high from launch until DONE state is entered
done  out  1  STATUS[0]; high in DONE state
result  out  WIDTH  M^T mod N; valid while done=1
mm_start  out  1  one-cycle pulse requesting a Montgomery multiply
mm_a  out  WIDTH  multiplier operand A, stable from mm_start until mm_done
mm_b  out  WIDTH  multiplier operand B, stable from mm_start until mm_done
mm_done  in  1  one-cycle pulse: mm_result valid
mm_result  in  WIDTH  MontMul(mm_a, mm_b) = a·b·R⁻¹ mod N

Behaviour:
- Reset: state IDLE; busy=0, done=0, mm_start=0; result, mm_a, mm_b, all internal registers = 0; start edge detector cleared.
- Launch: in IDLE, start=1 while start_q=0 latches all inputs. exp_len > EXP_W is clamped to EXP_W. Bit index i = len-1. busy=1 from the next cycle.
- States: IDLE, XT_ISSUE, XT_WAIT, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, FIN_ISSUE, FIN_WAIT, DONE.
- Each *_ISSUE state:
  - drives mm_a/mm_b and pulses mm_start for exactly 1 cycle;
  - moves to the matching *_WAIT state.
- Each *_WAIT state:
  - on the mm_done cycle, captures mm_result into the destination register;
  - transitions on the next clock.
  - Cost per multiply is L+2 cycles, where L is the number of cycles from mm_start to mm_done.
- Sequence:
  - XT: x̃ = MontMul(M, R²N). Then A = R_N. If len=0 go to FIN, else go to SQ.
  - SQ: A = MontMul(A, A). Then if exp[i]=1 go to MUL; else go to the bit-step.
  - MUL: A = MontMul(A, x̃). Then go to the bit-step.
  - Bit-step: if i=0 go to FIN; else i = i-1 and go to SQ.
  - FIN: A = MontMul(A, 1), with operand B = WIDTH'd1. result = A; go to DONE.
- DONE: done=1, busy=0, result held. When start=0, return to IDLE; done drops on that transition. start held high keeps DONE indefinitely with no relaunch.
- Total multiplies = 2 + len + popcount(exp[len-1:0]).
- Boundary cases:
  - start edges while busy are ignored.
  - mm_done outside a *_WAIT state is ignored.
  - len=0 gives result = 1 mod N.
  - exp bits at or above len are ignored.
  - resetn low mid-operation aborts immediately to IDLE. mm_start must not pulse again until the next launch.
  - The multiplier's modulus comes from the wrapper and is not routed through this block.

Decomposition:
- Package rsa_pkg holds:
  - state enum rsa_modexp_state_t;
  - localparams RSA_WIDTH=1024, RSA_EXP_W=32;
  - the ONE constant (WIDTH'd1).
- No sub-module; the bit index is a down-counter inside the FSM. The Montgomery multiplier is instantiated beside this block in the wrapper, not inside it.

Test Plan:
- Bench setup: WIDTH=16 with a behavioural MontMul model (R=2^16), fixed latency 5; N=13, M=2, T=0b101, len=3, R_N and R²_N precomputed.
  - Expected: result=6, done=1 after exactly 2+3+2=7 mm_start pulses.
- WIDTH=1024 RSA vector: N, M, R_N, R²_N as loaded by the DMA test; T=0x9985, len=16.
  - Expected: 25 mm_start pulses; result matches a software model of M^0x9985 mod N.
- len=0, T=0xFFFF.
  - Expected: 2 multiplies; result=1; bits of T ignored.
- start held high through DONE, then dropped, then raised again.
  - Expected: no relaunch while held high; done falls one cycle after start=0; second launch produces an identical result.
- resetn asserted during SQ_WAIT, with a spurious mm_done injected in IDLE.
  - Expected: busy=0, done=0, mm_start stays 0; the stray mm_done changes nothing.
- Second start edge mid-operation and exp_len=40 (> EXP_W).
  - Expected: the mid-operation edge is ignored; length is clamped to 32, giving multiply count 2+32+popcount(T).
